iter_block_cipher_core: RTL and testbench

- Responder end of the crypto block interface: accepts a key/plaintext load strobe from the register front end and returns a ciphertext with ready/busy/done/idle status.
- Implements an iterative toy SPN-less cipher with one round per clock, for power-analysis training traces.
- Sits in the crypto clock domain, in place of the example core under the block interface.
- trig_o drives the scope trigger for the whole computation window.

---
 rtl/iter_block_cipher_core.sv | 109 ++++++++++
 tb/tb_iter_block_cipher_core.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_block_cipher_core.sv
// Iterative toy cipher core: one round per clock behind a start/ready/busy/done handshake.
// Each round rotates the round key left by one byte and XORs in the round number; the state is rotated left by one bit and XORed with the new key.
module iter_block_cipher_core #(
    parameter int unsigned pWIDTH  = 128,
    parameter int unsigned pROUNDS = 10,
    parameter int unsigned pCNT_W  = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start_i,
    input  logic [pWIDTH-1:0] key_i,
    input  logic [pWIDTH-1:0] text_i,
    output logic [pWIDTH-1:0] cipher_o,
    output logic              ready_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              idle_o,
    output logic              trig_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Only the low byte of the round counter is mixed into the key.
    localparam int unsigned RND_BITS = (pCNT_W < 8) ? pCNT_W : 8;

    state_e            state_q;
    logic [pWIDTH-1:0] st_q;
    logic [pWIDTH-1:0] rk_q;
    logic [pWIDTH-1:0] cipher_q;
    logic [pCNT_W-1:0] rnd_q;
    logic              busy_q;
    logic              done_q;
    logic              trig_q;

    logic [7:0]        rnd_byte;
    logic [pWIDTH-1:0] rk_d;
    logic [pWIDTH-1:0] st_d;
    logic              last_round;

    // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
    always_comb begin
        rnd_byte   = 8'(rnd_q[RND_BITS-1:0]);
        rk_d       = {rk_q[pWIDTH-9:0], rk_q[pWIDTH-1:pWIDTH-8]}
                     ^ {{(pWIDTH-8){1'b0}}, rnd_byte};
        st_d       = {st_q[pWIDTH-2:0], st_q[pWIDTH-1]} ^ rk_d;
        last_round = (rnd_q == pCNT_W'(pROUNDS));
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            st_q     <= '0;
            rk_q     <= '0;
            cipher_q <= '0;
            rnd_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            trig_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        st_q    <= text_i ^ key_i;
                        rk_q    <= key_i;
                        rnd_q   <= pCNT_W'(1);
                        state_q <= ROUND;
                        busy_q  <= 1'b1;
                        trig_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ROUND: begin
                    rk_q <= rk_d;
                    st_q <= st_d;
                    if (last_round) begin
                        cipher_q <= st_d;
                        state_q  <= DONE;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        trig_q   <= 1'b0;
                    end else begin
                        rnd_q <= rnd_q + pCNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    trig_q  <= 1'b0;
                end
            endcase
        end
    end

    // Status decoded from the state register alone, never from inputs.
    assign ready_o  = (state_q != ROUND);
    assign idle_o   = (state_q != ROUND);
    assign cipher_o = cipher_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign trig_o   = trig_q;

endmodule

// File: tb/tb_iter_block_cipher_core.sv
// Scoreboard bench for iter_block_cipher_core: three instances (10, 2 and 1 rounds) share clock and reset.
// Stimulus pushes expected ciphertexts; a negedge monitor pops them on done_o and checks latency and status.
module tb_iter_block_cipher_core;

    localparam int W = 128;
    localparam logic [W-1:0] MSB = {1'b1, {(W-1){1'b0}}};

    typedef struct {
        logic [W-1:0] cipher;
        int unsigned  acc;
    } exp_t;

    logic         clk;
    logic         resetn;
    logic         start  [3];
    logic [W-1:0] key    [3];
    logic [W-1:0] text   [3];
    logic [W-1:0] cipher [3];
    logic         ready  [3];
    logic         busy   [3];
    logic         done   [3];
    logic         idle   [3];
    logic         trig   [3];

    exp_t         sbq [3][$];
    logic [W-1:0] last_c [3];
    int           bcnt [3];
    int unsigned  cyc = 0;
    bit           armed = 1'b0;
    bit           rst_seen = 1'b0;
    int           n_cmp = 0;
    int           n_fail = 0;
    exp_t         mon_e;

    iter_block_cipher_core #(.pWIDTH(W), .pROUNDS(10), .pCNT_W(8)) u_r10 (
        .clk(clk), .resetn(resetn), .start_i(start[0]), .key_i(key[0]), .text_i(text[0]),
        .cipher_o(cipher[0]), .ready_o(ready[0]), .busy_o(busy[0]), .done_o(done[0]),
        .idle_o(idle[0]), .trig_o(trig[0])
    );
    iter_block_cipher_core #(.pWIDTH(W), .pROUNDS(2), .pCNT_W(8)) u_r2 (
        .clk(clk), .resetn(resetn), .start_i(start[1]), .key_i(key[1]), .text_i(text[1]),
        .cipher_o(cipher[1]), .ready_o(ready[1]), .busy_o(busy[1]), .done_o(done[1]),
        .idle_o(idle[1]), .trig_o(trig[1])
    );
    iter_block_cipher_core #(.pWIDTH(W), .pROUNDS(1), .pCNT_W(8)) u_r1 (
        .clk(clk), .resetn(resetn), .start_i(start[2]), .key_i(key[2]), .text_i(text[2]),
        .cipher_o(cipher[2]), .ready_o(ready[2]), .busy_o(busy[2]), .done_o(done[2]),
        .idle_o(idle[2]), .trig_o(trig[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    function automatic int rounds_of(input int i);
        case (i)
            0:       return 10;
            1:       return 2;
            default: return 1;
        endcase
    endfunction

    // Reference cipher: applies the round function sequentially for the given round count.
    function automatic logic [W-1:0] model(input logic [W-1:0] k, input logic [W-1:0] t, input int rounds);
        logic [W-1:0] s;
        logic [W-1:0] r;
        logic [7:0]   nb;
        s = t ^ k;
        r = k;
        for (int n = 1; n <= rounds; n++) begin
            nb = 8'(n);
            r  = {r[W-9:0], r[W-1:W-8]} ^ {{(W-8){1'b0}}, nb};
            s  = {s[W-2:0], s[W-1]} ^ r;
        end
        return s;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [W-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= !resetn;
        armed    <= 1'b1;
    end

    // Monitor: pops the scoreboard whenever an instance presents done_o.
    always @(negedge clk) begin
        if (armed) begin
            for (int i = 0; i < 3; i++) begin
                if (rst_seen) begin
                    sbq[i].delete();
                    last_c[i] = '0;
                    bcnt[i]   = 0;
                end
                check($sformatf("trig_eq_busy[%0d]", i), W'(trig[i]), W'(busy[i]));
                check($sformatf("ready_not_busy[%0d]", i), W'(ready[i]), W'(!busy[i]));
                check($sformatf("idle_eq_ready[%0d]", i), W'(idle[i]), W'(ready[i]));
                if (done[i]) begin
                    if (sbq[i].size() == 0) begin
                        check($sformatf("unexpected_done[%0d]", i), W'(1), W'(0));
                    end else begin
                        mon_e = sbq[i].pop_front();
                        check($sformatf("cipher[%0d]", i), cipher[i], mon_e.cipher);
                        check($sformatf("latency[%0d]", i), W'(cyc - mon_e.acc), W'(rounds_of(i)));
                        check($sformatf("busy_cycles[%0d]", i), W'(bcnt[i]), W'(rounds_of(i)));
                        last_c[i] = mon_e.cipher;
                    end
                    bcnt[i] = 0;
                end else begin
                    check($sformatf("cipher_hold[%0d]", i), cipher[i], last_c[i]);
                    if (busy[i]) bcnt[i]++;
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input int i, input logic [W-1:0] k, input logic [W-1:0] t, input logic [W-1:0] expv);
        int   budget;
        exp_t e;
        budget = 0;
        while (!ready[i] && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (!ready[i]) begin
            check($sformatf("issue_ready_timeout[%0d]", i), W'(0), W'(1));
        end else begin
            start[i] = 1'b1;
            key[i]   = k;
            text[i]  = t;
            e.cipher = expv;
            e.acc    = cyc + 1;
            sbq[i].push_back(e);
            @(negedge clk);
            start[i] = 1'b0;
            key[i]   = ~k;
            text[i]  = rnd128();
        end
    endtask

    task automatic drain();
        int b;
        b = 0;
        while ((sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0 && b < 200) begin
            @(negedge clk);
            b++;
        end
        check("drain_pending", W'(sbq[0].size() + sbq[1].size() + sbq[2].size()), W'(0));
        @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] k;
        logic [W-1:0] t;

        // Reset held two edges with start asserted on every instance.
        resetn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b1;
            key[i]   = rnd128();
            text[i]  = rnd128();
        end
        repeat (2) begin
            @(negedge clk);
            check("rst_cipher", cipher[0], '0);
            check("rst_ready", W'(ready[0]), W'(1));
            check("rst_idle", W'(idle[0]), W'(1));
            check("rst_busy", W'(busy[0]), W'(0));
            check("rst_done", W'(done[0]), W'(0));
        end
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) start[i] = 1'b0;
        repeat (3) @(negedge clk);

        // Hand-computed vectors for the 2-round and 1-round instances.
        issue(1, '0, '0, 128'h100);
        issue(1, 128'h1, '0, 128'h10304);
        issue(1, '0, MSB, 128'h102);
        issue(2, '0, 128'h1, 128'h3);
        issue(2, '0, MSB, 128'h0);
        drain();

        // 1000 random operations on the 10-round instance, with ignored mid-run start pulses.
        for (int n = 0; n < 1000; n++) begin
            k = rnd128();
            t = rnd128();
            issue(0, k, t, model(k, t, 10));
            if (n % 4 == 0) begin
                repeat (3) @(negedge clk);
                start[0] = 1'b1;
                key[0]   = rnd128();
                text[0]  = rnd128();
                @(negedge clk);
                start[0] = 1'b0;
            end
        end
        drain();

        // start_i held high on the 2-round instance: accepts every third edge.
        for (int c = 0; c < 15; c++) begin
            exp_t e;
            k = rnd128();
            t = rnd128();
            start[1] = 1'b1;
            key[1]   = k;
            text[1]  = t;
            if (c % 3 == 0) begin
                e.cipher = model(k, t, 2);
                e.acc    = cyc + 1;
                sbq[1].push_back(e);
            end
            @(negedge clk);
        end
        start[1] = 1'b0;
        drain();

        // Reset applied on the fourth round edge of a 10-round operation.
        k = rnd128();
        t = rnd128();
        issue(0, k, t, model(k, t, 10));
        repeat (3) @(negedge clk);
        check("busy_before_reset", W'(busy[0]), W'(1));
        resetn = 1'b0;
        @(negedge clk);
        check("abort_busy", W'(busy[0]), W'(0));
        check("abort_idle", W'(idle[0]), W'(1));
        check("abort_cipher", cipher[0], '0);
        check("abort_done", W'(done[0]), W'(0));
        resetn = 1'b1;
        repeat (15) @(negedge clk);
        k = rnd128();
        t = rnd128();
        issue(0, k, t, model(k, t, 10));
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
